// File: rtl/memory_responder.sv
// memory_responder: word RAM bus slave with cyc/stb/ack handshake, wait states, byte lanes and range error
module memory_responder #(
    parameter int          DEPTH_WORDS  = 1024,
    parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000,
    parameter int          WAIT_STATES  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic        we_i,
    input  logic [31:0] adr_i,
    input  logic [31:0] dat_i,
    input  logic [3:0]  sel_i,
    output logic [31:0] dat_o,
    output logic        ack_o,
    output logic        err_o
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [32:0] LIMIT = {1'b0, BASE_ADDRESS} + 33'(4 * DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES == 0 ? 0 : WAIT_STATES - 1);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t state, state_next;
    logic [3:0] cnt, cnt_next;
    logic [31:0] mem [DEPTH_WORDS];
    logic l_we, l_ok;
    logic [AW-1:0] l_idx;
    logic [31:0] l_dat;
    logic [3:0] l_sel;
    logic in_ok, accept, enter_resp, r_we, r_ok;
    logic [AW-1:0] in_idx, r_idx;
    logic [31:0] r_dat;
    logic [3:0] r_sel;
    assign in_ok = adr_i >= BASE_ADDRESS && {1'b0, adr_i} < LIMIT;
    assign in_idx = AW'((adr_i - BASE_ADDRESS) >> 2);
    assign accept = state == IDLE && cyc_i && stb_i;
    assign r_we = accept ? we_i : l_we;
    assign r_ok = accept ? in_ok : l_ok;
    assign r_idx = accept ? in_idx : l_idx;
    assign r_dat = accept ? dat_i : l_dat;
    assign r_sel = accept ? sel_i : l_sel;
    assign ack_o = state == RESP && l_ok;
    assign err_o = state == RESP && !l_ok;
    assign enter_resp = state_next == RESP;
    always_comb begin
        state_next = state;
        cnt_next = cnt;
        case (state)
            IDLE: begin
                state_next = accept ? (WAIT_STATES == 0 ? RESP : WAIT) : IDLE;
                cnt_next = accept ? CNT_INIT : cnt;
            end
            WAIT: begin
                state_next = !cyc_i ? IDLE : cnt == 4'd0 ? RESP : WAIT;
                cnt_next = cyc_i && cnt != 4'd0 ? cnt - 4'd1 : cnt;
            end
            default: state_next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt <= 4'd0;
            dat_o <= 32'h0;
        end else begin
            state <= state_next;
            cnt <= cnt_next;
            if (enter_resp && !(r_we && r_ok))
                dat_o <= r_ok ? mem[r_idx] : 32'h0;
        end
    end
    always_ff @(posedge clk) begin
        if (accept) begin
            l_we <= we_i;
            l_ok <= in_ok;
            l_idx <= in_idx;
            l_dat <= dat_i;
            l_sel <= sel_i;
        end
    end
    always_ff @(posedge clk) begin
        if (!reset && enter_resp && r_we && r_ok)
            for (int k = 0; k < 4; k++)
                if (r_sel[k]) mem[r_idx][8*k +: 8] <= r_dat[8*k +: 8];
    end
endmodule

// File: tb/tb_memory_responder.sv
// tb_memory_responder: randomized scoreboard bench for memory_responder plus latency checks at 0 and 3 wait states
module tb_memory_responder;
    localparam int DEPTH = 256;
    localparam int WS = 1;
    logic clk = 0, reset = 1;
    always #5 clk = ~clk;
    logic cyc_i = 0, stb_i = 0, we_i = 0;
    logic [31:0] adr_i = 0, dat_i = 0;
    logic [3:0] sel_i = 0;
    logic [31:0] dat_o, dat0, dat3;
    logic ack_o, err_o, ack0, err0, ack3, err3;
    logic cyc_b = 0, stb_b = 0;
    int checks = 0, errors = 0;
    typedef struct {
        logic        err;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] last_dat = 0;
    memory_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDRESS(32'h0), .WAIT_STATES(WS)) dut (
        .clk(clk), .reset(reset), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i), .adr_i(adr_i),
        .dat_i(dat_i), .sel_i(sel_i), .dat_o(dat_o), .ack_o(ack_o), .err_o(err_o));
    memory_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDRESS(32'h0), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset), .cyc_i(cyc_b), .stb_i(stb_b), .we_i(1'b0), .adr_i(32'h0),
        .dat_i(32'h0), .sel_i(4'hF), .dat_o(dat0), .ack_o(ack0), .err_o(err0));
    memory_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDRESS(32'h0), .WAIT_STATES(3)) dut3 (
        .clk(clk), .reset(reset), .cyc_i(cyc_b), .stb_i(stb_b), .we_i(1'b0), .adr_i(32'h0),
        .dat_i(32'h0), .sel_i(4'hF), .dat_o(dat3), .ack_o(ack3), .err_o(err3));
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        exp_t e;
        int lat;
        bit got;
        logic ok;
        int idx;
        ok = a < 32'(4 * DEPTH);
        idx = int'(a >> 2) % DEPTH;
        if (ok && w)
            for (int k = 0; k < 4; k++)
                if (s[k]) ref_mem[idx][8*k +: 8] = d[8*k +: 8];
        if (!ok || !w) last_dat = ok ? ref_mem[idx] : 32'h0;
        e.err = !ok;
        e.data = last_dat;
        sb.push_back(e);
        cyc_i = 1; stb_i = 1; we_i = w; adr_i = a; dat_i = d; sel_i = s;
        @(posedge clk);
        #1;
        stb_i = 0; we_i = $urandom; adr_i = $urandom; dat_i = $urandom; sel_i = $urandom;
        lat = 0;
        got = ack_o || err_o;
        while (!got && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            got = ack_o || err_o;
        end
        check("latency", got ? lat + 1 : 99, WS + 1);
        cyc_i = 0;
        @(posedge clk);
        #1;
    endtask
    task automatic quiet(input string name, input int n);
        logic seen = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
            seen |= ack_o | err_o;
        end
        check(name, seen, 0);
    endtask
    function automatic logic b2b_exp(input int n, input int ws);
        return n >= 1 + ws && (n - 1 - ws) % (ws + 2) == 0;
    endfunction
    initial begin : monitor
        exp_t e;
        logic prev = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev = 0;
                continue;
            end
            if (ack_o || err_o) begin
                check("ack_err_exclusive", ack_o & err_o, 0);
                check("no_adjacent_resp", prev, 0);
                if (sb.size() == 0) check("unexpected_resp", 1, 0);
                else begin
                    e = sb.pop_front();
                    check("resp_err", err_o, e.err);
                    check("resp_ack", ack_o, !e.err);
                    check("resp_dat", dat_o, e.data);
                end
            end
            prev = ack_o || err_o;
        end
    end
    initial begin
        logic [31:0] a;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ack", ack_o, 0);
        check("rst_err", err_o, 0);
        check("rst_dat", dat_o, 0);
        reset = 0;
        for (int i = 0; i < DEPTH; i++) xfer(1, 32'(i * 4), $urandom, 4'hF);
        xfer(1, 32'h10, 32'hDEADBEEF, 4'hF);
        xfer(0, 32'h10, 0, 4'h0);
        xfer(1, 32'h20, 32'h11223344, 4'hF);
        xfer(1, 32'h20, 32'hAABBCCDD, 4'b0101);
        xfer(0, 32'h20, 0, 4'hF);
        check("lane_model", ref_mem[8], 32'h11BB33DD);
        xfer(1, 32'h20, 32'h55667788, 4'h0);
        xfer(0, 32'h20, 0, 4'h3);
        xfer(0, 32'h400, 0, 4'hF);
        xfer(1, 32'h400, 32'h12345678, 4'hF);
        xfer(0, 32'h0, 0, 4'hF);
        xfer(0, 32'hFFFF_FFFC, 0, 4'hF);
        for (int i = 0; i < 150; i++) begin
            a = ($urandom % 8 == 0) ? 32'h400 + $urandom % 32'h1000_0000 : 32'(($urandom % DEPTH) * 4 + $urandom % 4);
            xfer(1'($urandom), a, $urandom, 4'($urandom));
        end
        cyc_i = 1; stb_i = 1; we_i = 1; adr_i = 32'h30; dat_i = 32'hCAFEF00D; sel_i = 4'hF;
        @(posedge clk);
        #1;
        cyc_i = 0; stb_i = 0;
        quiet("abort_no_resp", 4);
        xfer(0, 32'h30, 0, 4'hF);
        cyc_i = 1; stb_i = 1; we_i = 1; adr_i = 32'h34; dat_i = 32'h0BADF00D; sel_i = 4'hF;
        @(posedge clk);
        #1;
        stb_i = 0;
        reset = 1;
        @(posedge clk);
        #1;
        check("midrst_ack", ack_o, 0);
        check("midrst_err", err_o, 0);
        check("midrst_dat", dat_o, 0);
        reset = 0;
        cyc_i = 0;
        last_dat = 0;
        quiet("midrst_no_resp", 4);
        xfer(0, 32'h34, 0, 4'hF);
        cyc_b = 1; stb_b = 1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            check("ws0_b2b", {err0, ack0}, {1'b0, b2b_exp(n, 0)});
            check("ws3_b2b", {err3, ack3}, {1'b0, b2b_exp(n, 3)});
        end
        cyc_b = 0; stb_b = 0;
        repeat (2) @(posedge clk);
        check("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
